data_memory_ws: RTL

//  Parametrised data memory for the processor datapath, successor to the single-port 16-bit store.

---
 rtl/data_memory_ws_if.sv | 26 ++
 rtl/data_memory_ws.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/data_memory_ws_if.sv
// rtl/data_memory_ws_if.sv - request/response bus between the MEM stage and data_memory_ws
// The master holds req and the access fields until it sees ready at a clock edge.
interface data_memory_ws_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  ready;
  logic                  ack;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, ack, rdata, err
  );
endinterface

// File: rtl/data_memory_ws.sv
// rtl/data_memory_ws.sv - data memory with req/ready/ack handshake, wait states and byte enables
// The array is touched exactly once per request, on the edge that enters RESP.
module data_memory_ws #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1600,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  data_memory_ws_if.slave   bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                acc_en;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [BE_W-1:0]     acc_be;
  logic                acc_in_range;
  logic [IDX_W-1:0]    acc_idx;
  logic                mem_wr;

  logic [DATA_W-1:0]   mem [DEPTH];

  // With zero wait states the access happens on the accepting edge, so take operands straight from the bus.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == S_IDLE) begin
      acc_we    = bus.we;
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
      acc_be    = bus.be;
    end
    acc_in_range = ({1'b0, acc_addr} < DEPTH_V);
    acc_idx      = acc_addr[IDX_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    acc_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          be_d    = bus.be;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
            acc_en  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          acc_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (acc_en) begin
      if (!acc_in_range) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        err_d = 1'b0;
        if (!acc_we) begin
          rdata_d = mem[acc_idx];
        end
      end
    end
  end

  // Gating with reset_n drops a write whose RESP-entry edge lands inside reset.
  assign mem_wr = acc_en && acc_we && acc_in_range && reset_n;

  always_ff @(posedge clock) begin
    if (mem_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.ack   = (state_q == S_RESP);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule
